ex_div_unit: RTL and testbench

Multi-cycle iterative integer divider in the execute stage of the 5-stage MIPS pipeline. It consumes decoded divide operations (ALU control code 3'b011) carried from decode through ID/EX, and produces quotient and remainder after a fixed radix-2 restoring sequence. While it runs, it stalls the IF, ID and EX stages.

---
 rtl/mips_pkg.sv | 19 +
 rtl/div_core.sv | 83 ++++++++
 rtl/ex_div_unit.sv | 148 ++++++++++++++
 tb/tb_ex_div_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
// Holds the ALU control encodings driven from decode through ID/EX, and the
// state type of the iterative divider in EX.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider datapath with its iteration counter.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : load operands, clear partial remainder, counter = Width-1
//   step_i         : perform one shift / trial-subtract iteration
//   dividend_i     : unsigned dividend (magnitude)
//   divisor_i      : unsigned divisor (magnitude)
//   last_o         : counter is 0, the current step is the final one
//   quo_next_o     : quotient after the current step
//   rem_next_o     : remainder after the current step
module div_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             last_o,
  output logic [Width-1:0] quo_next_o,
  output logic [Width-1:0] rem_next_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [Width:0]   partial;
  logic [Width+1:0] trial;
  logic             no_borrow;
  logic [Width-1:0] quo_step;
  logic [Width-1:0] rem_step;

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // subtract is one bit wider than the operands plus a borrow bit.
  always_comb begin
    partial   = {rem_q, quo_q[Width-1]};
    trial     = {1'b0, partial} - {2'b00, div_q};
    no_borrow = ~trial[Width+1];
    quo_step  = {quo_q[Width-2:0], no_borrow};
    // On no borrow the difference is below the divisor, so it fits in Width bits.
    rem_step  = no_borrow ? Width'(trial) : Width'(partial);
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      div_d = divisor_i;
      cnt_d = CntW'(Width - 1);
    end else if (step_i) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o     = (cnt_q == '0);
  assign quo_next_o = quo_step;
  assign rem_next_o = rem_step;

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle signed/unsigned integer divider in the EX stage.
// Wraps the unsigned div_core with sign handling, the control FSM and
// flush/stall logic; stalls IF/ID/EX while the iteration runs.
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : valid divide held in EX (level)
//   signed_i        : 1 = div, 0 = divu; sampled on accept
//   flush_i         : kill in-flight divide / suppress acceptance
//   dividend_i      : SrcAE operand
//   divisor_i       : SrcBE operand
//   quotient_o      : registered quotient, held until the next result
//   remainder_o     : registered remainder, held likewise
//   busy_o          : FSM not idle
//   done_o          : one-cycle pulse, results valid
//   div_by_zero_o   : registered with results, divisor was zero
//   stall_o         : stall request to the hazard unit
module ex_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic             stall_o
);

  div_state_t state_q, state_d;

  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             divisor_zero;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic             core_load;
  logic             core_step;
  logic             core_last;
  logic [WIDTH-1:0] core_quo;
  logic [WIDTH-1:0] core_rem;

  assign accept       = (state_q == IDLE) && start_i && !flush_i;
  assign divisor_zero = (divisor_i == '0);
  assign dividend_neg = signed_i & dividend_i[WIDTH-1];
  assign divisor_neg  = signed_i & divisor_i[WIDTH-1];
  // MIN_INT negates to itself, which is its correct unsigned magnitude.
  assign dividend_abs = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_abs  = divisor_neg ? -divisor_i : divisor_i;

  assign core_load = accept;
  assign core_step = (state_q == RUN) && !flush_i;

  div_core #(
    .Width(WIDTH)
  ) u_div_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (core_load),
    .step_i     (core_step),
    .dividend_i (dividend_abs),
    .divisor_i  (divisor_abs),
    .last_o     (core_last),
    .quo_next_o (core_quo),
    .rem_next_o (core_rem)
  );

  always_comb begin
    state_d     = state_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          quo_neg_d = dividend_neg ^ divisor_neg;
          rem_neg_d = dividend_neg;
          if (divisor_zero) begin
            // Divide by zero completes without iterating; remainder is the raw operand.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (core_last) begin
          state_d     = DONE;
          quotient_d  = quo_neg_q ? -core_quo : core_quo;
          remainder_d = rem_neg_q ? -core_rem : core_rem;
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        // A start seen here belongs to the divide now leaving EX.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign busy_o        = (state_q != IDLE);
  // A flush in DONE retires nothing, so the pulse is masked.
  assign done_o        = (state_q == DONE) && !flush_i;
  assign stall_o       = accept || (state_q == RUN);

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit (WIDTH = 32).
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        stall;

  int errors = 0;
  int checks = 0;

  ex_div_unit #(
    .WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .signed_i      (sgn),
    .flush_i       (flush),
    .dividend_i    (a),
    .divisor_i     (b),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .busy_o        (busy),
    .done_o        (done),
    .div_by_zero_o (dbz),
    .stall_o       (stall)
  );

  always #5 clk = ~clk;

  // Issue one divide and hold start until done; checks latency, stall profile and results.
  task automatic do_div(input string name, input logic s, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat);
    int   n;
    logic seen;
    logic stall_ok;
    @(posedge clk); #1;
    start = 1'b1; sgn = s; a = x; b = y;
    @(negedge clk);
    stall_ok = (stall === 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        if (stall !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    checks++;
    if (!seen || n !== elat) begin
      errors++;
      $display("FAIL %s latency: got %0d seen=%0b want %0d", name, n, seen, elat);
    end
    checks++;
    if (!stall_ok) begin
      errors++;
      $display("FAIL %s stall profile: got irregular stall_o want high until done", name);
    end
    checks++;
    if (quotient !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %h want %h", name, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      errors++;
      $display("FAIL %s remainder: got %h want %h", name, remainder, er);
    end
    checks++;
    if (dbz !== edbz) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b want %b", name, dbz, edbz);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; flush = 1'b0; a = '0; b = '0;
    @(negedge clk);
    checks++;
    if ({quotient, remainder} !== 64'd0) begin
      errors++;
      $display("FAIL reset results: got %h/%h want 0/0", quotient, remainder);
    end
    checks++;
    if ({busy, done, dbz, stall} !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags: got busy/done/dbz/stall=%b want 0000",
               {busy, done, dbz, stall});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    do_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    do_div("udiv_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 33);
    do_div("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    do_div("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
  endtask

  task automatic test_div_by_zero();
    do_div("udiv_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    do_div("sdiv_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
  endtask

  task automatic test_flush();
    logic saw_done;
    do_div("flush_pre", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5;
    @(posedge clk);               // accept edge
    repeat (9) @(posedge clk);    // now in RUN cycle 10
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush busy_before: got %b want 1", busy);
    end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush busy_after: got %b want 0", busy);
    end
    checks++;
    if ({quotient, remainder} !== {32'd14, 32'd2}) begin
      errors++;
      $display("FAIL flush results_held: got %0d/%0d want 14/2", quotient, remainder);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL flush no_done: got done_o pulse want none");
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (6) @(posedge clk);
    #2;
    start = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder} !== 64'd0) begin
      errors++;
      $display("FAIL midreset results: got %h/%h want 0/0", quotient, remainder);
    end
    checks++;
    if ({busy, done, dbz, stall} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset flags: got busy/done/dbz/stall=%b want 0000",
               {busy, done, dbz, stall});
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    do_div("after_reset_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
  endtask

  task automatic test_back_to_back();
    int   n;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; sgn = 1'b0; a = 32'd20; b = 32'd4;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== 34 || quotient !== 32'd5 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL b2b first: got n=%0d q=%0d r=%0d want n=34 q=5 r=0",
               n, quotient, remainder);
    end
    // Next instruction enters EX with start still high.
    @(posedge clk); #1;
    a = 32'd21; b = 32'd4;
    @(negedge clk);
    checks++;
    if ({stall, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL b2b accept: got stall/busy/done=%b want 100", {stall, busy, done});
    end
    n = 1;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n !== 34) begin
      errors++;
      $display("FAIL b2b done_gap: got %0d seen=%0b want 34", n, seen);
    end
    checks++;
    if ({quotient, remainder} !== {32'd5, 32'd1}) begin
      errors++;
      $display("FAIL b2b second: got %0d/%0d want 5/1", quotient, remainder);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
